// File: rtl/read_port_cdt.sv
// read_port_cdt
//   Credit-managed read port between one requester and GRP_NUM image-group
//   arbiters. A one-hot group request goes to the selected arbiter. A credit
//   check bounds reads in flight so the return FIFO can never overflow.
//   Returned data is merged into a register FIFO and presented through a
//   valid/ready output register. Sticky error flags are kept for debug.
//
//   Optional feature: define READ_PORT_PERF_CNT_EN to build saturating
//   request/stall performance counters. Without it, both ports read 0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   read_group_id_i/bank_en_i/addr_i   request (one-hot group select)
//   read_addr_ready_o              request fired this cycle
//   read_data_valid_o/data_o/ready_i   output stream
//   read_en_grp_o, read_bank_en_grp_o, read_addr_grp_o   per-group request
//   read_addr_ready_grp_i          per-group accept
//   read_data_valid_grp_i, read_data_grp_i   per-group return
//   err_clr_i, err_flags_o         {underflow, multi-return, multi-request}
//   perf_req_cnt_o, perf_stall_cnt_o   performance counters
module read_port_cdt #(
  parameter int GRP_NUM    = 3,
  parameter int ROW_PARA   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 32,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [GRP_NUM-1:0]             read_group_id_i,
  input  logic [ROW_PARA-1:0]            read_bank_en_i,
  input  logic [ADDR_WIDTH-1:0]          read_addr_i,
  output logic                           read_addr_ready_o,
  output logic                           read_data_valid_o,
  output logic [DATA_WIDTH-1:0]          read_data_o,
  input  logic                           read_data_ready_i,
  output logic [GRP_NUM-1:0]             read_en_grp_o,
  output logic [GRP_NUM*ROW_PARA-1:0]    read_bank_en_grp_o,
  output logic [GRP_NUM*ADDR_WIDTH-1:0]  read_addr_grp_o,
  input  logic [GRP_NUM-1:0]             read_addr_ready_grp_i,
  input  logic [GRP_NUM-1:0]             read_data_valid_grp_i,
  input  logic [GRP_NUM*DATA_WIDTH-1:0]  read_data_grp_i,
  input  logic                           err_clr_i,
  output logic [2:0]                     err_flags_o,
  output logic [31:0]                    perf_req_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [2:0]            err_q;

  logic                  req_ok, req_multi, credit_ok, sel_ready, fire;
  logic                  ret, ret_multi, ret_underflow, push, pop;
  logic [CNT_W:0]        inflight;
  logic [DATA_WIDTH-1:0] ret_data;

  // Stage p0: combinational request and return decode
  always_comb begin
    req_ok    = $onehot(read_group_id_i);
    req_multi = !$onehot0(read_group_id_i);
    inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
    credit_ok = inflight < DEPTH_SUM;
    sel_ready = |(read_addr_ready_grp_i & read_group_id_i);
    fire      = req_ok && credit_ok && sel_ready;

    ret           = |read_data_valid_grp_i;
    ret_multi     = !$onehot0(read_data_valid_grp_i);
    ret_underflow = ret && (outstanding == '0);
    // Several groups returning at once is an error; their slices are merged
    // into one entry rather than dropped.
    ret_data = '0;
    for (int g = 0; g < GRP_NUM; g++) begin
      ret_data = ret_data |
                 (read_data_grp_i[g*DATA_WIDTH +: DATA_WIDTH] &
                  {DATA_WIDTH{read_data_valid_grp_i[g]}});
    end

    pop  = (!vld_p1 || read_data_ready_i) && (fifo_count != '0);
    // Credits keep the FIFO from filling; the guard only protects the
    // pointers against a misbehaving arbiter.
    push = ret && ((fifo_count != DEPTH_CNT) || pop);
  end

  assign read_en_grp_o      = read_group_id_i & {GRP_NUM{req_ok && credit_ok}};
  assign read_addr_ready_o  = fire;
  assign read_bank_en_grp_o = {GRP_NUM{read_bank_en_i}};
  assign read_addr_grp_o    = {GRP_NUM{read_addr_i}};

  // Stage p0 -> FIFO: credit counter, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (fire && !ret)
        outstanding <= outstanding + CNT_W'(1);
      else if (!fire && ret && (outstanding != '0))
        outstanding <= outstanding - CNT_W'(1);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)
        fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop)
        fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ret_data;
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      data_p1 <= mem[rd_ptr];
    end else if (read_data_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign read_data_valid_o = vld_p1;
  assign read_data_o       = data_p1;

  // Sticky error flags; a new event in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else
      err_q <= (err_clr_i ? 3'b000 : err_q) | {ret_underflow, ret_multi, req_multi};
  end

  assign err_flags_o = err_q;

`ifdef READ_PORT_PERF_CNT_EN
  logic [31:0] req_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire && (req_cnt != '1))
        req_cnt <= req_cnt + 32'd1;
      if (vld_p1 && !read_data_ready_i && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_req_cnt_o   = req_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_req_cnt_o   = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_read_port_cdt.sv
module tb_read_port_cdt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   grp_id;
  logic [3:0]   bank_en;
  logic [47:0]  addr;
  logic         addr_ready;
  logic         data_valid;
  logic [255:0] data;
  logic         data_ready;
  logic [2:0]   en_grp;
  logic [11:0]  bank_en_grp;
  logic [143:0] addr_grp;
  logic [2:0]   addr_ready_grp;
  logic [2:0]   data_valid_grp;
  logic [767:0] data_grp;
  logic         err_clr;
  logic [2:0]   err_flags;
  logic [31:0]  perf_req, perf_stall;

  int n_chk  = 0;
  int n_pass = 0;
  logic [255:0] sb[$];
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data  = '0;
  logic [31:0]  stall_base, req_base;

  always #5 clk = ~clk;

  read_port_cdt dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .read_group_id_i       (grp_id),
    .read_bank_en_i        (bank_en),
    .read_addr_i           (addr),
    .read_addr_ready_o     (addr_ready),
    .read_data_valid_o     (data_valid),
    .read_data_o           (data),
    .read_data_ready_i     (data_ready),
    .read_en_grp_o         (en_grp),
    .read_bank_en_grp_o    (bank_en_grp),
    .read_addr_grp_o       (addr_grp),
    .read_addr_ready_grp_i (addr_ready_grp),
    .read_data_valid_grp_i (data_valid_grp),
    .read_data_grp_i       (data_grp),
    .err_clr_i             (err_clr),
    .err_flags_o           (err_flags),
    .perf_req_cnt_o        (perf_req),
    .perf_stall_cnt_o      (perf_stall)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one return cycle: every group in mask carries d; expected entry is d.
  task automatic ret_cycle(input logic [2:0] mask, input logic [255:0] d);
    data_valid_grp = mask;
    for (int g = 0; g < 3; g++) data_grp[g*256 +: 256] = mask[g] ? d : '0;
    sb.push_back(d);
    tick();
    data_valid_grp = '0;
    data_grp       = '0;
  endtask

  task automatic fire_n(input int n);
    grp_id = 3'b001;
    repeat (n) tick();
    grp_id = 3'b000;
  endtask

  // Scoreboard and hold-stable monitor on the output stream
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", {255'd0, data_valid}, 256'd1);
        check("hold_data", data, prev_data);
      end
      if (data_valid && data_ready) begin
        n_chk++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL sb_extra: got %0h expected no output", data);
        if (sb.size() != 0) check("sb_data", data, sb.pop_front());
      end
      prev_stall = data_valid && !data_ready;
      prev_data  = data;
    end
  end

  initial begin
    rst_n = 1'b0; grp_id = '0; bank_en = 4'hF; addr = '0; data_ready = 1'b1;
    addr_ready_grp = 3'b111; data_valid_grp = '0; data_grp = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", {255'd0, data_valid}, 256'd0);
    check("rst_data", data, 256'd0);
    check("rst_err", {253'd0, err_flags}, 256'd0);
    check("rst_perf_req", {224'd0, perf_req}, 256'd0);
    check("rst_en", {253'd0, en_grp}, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single request to group 1 and its return
    grp_id = 3'b010; addr = 48'h100; addr_ready_grp = 3'b010;
    @(negedge clk);
    check("t1_en", {253'd0, en_grp}, 256'h2);
    check("t1_fire", {255'd0, addr_ready}, 256'd1);
    check("t1_addr_rep", {112'd0, addr_grp}, {112'd0, {3{48'h100}}});
    check("t1_bank_rep", {244'd0, bank_en_grp}, 256'hFFF);
    tick();
    grp_id = 3'b000; addr_ready_grp = 3'b111;
    data_valid_grp = 3'b010; data_grp[256 +: 256] = 256'hAA; sb.push_back(256'hAA);
    tick();
    data_valid_grp = '0; data_grp = '0;
    @(negedge clk);
    check("t1_vld_t", {255'd0, data_valid}, 256'd0);
    tick();
    @(negedge clk);
    check("t1_vld_t1", {255'd0, data_valid}, 256'd1);
    check("t1_data_t1", data, 256'hAA);
    repeat (3) tick();

    // Credit exhaustion and release
    data_ready = 1'b0;
    fire_n(32);
    grp_id = 3'b001;
    @(negedge clk);
    check("cr_block_fire", {255'd0, addr_ready}, 256'd0);
    check("cr_block_en", {253'd0, en_grp}, 256'd0);
    grp_id = 3'b000;
    for (int i = 0; i < 32; i++) ret_cycle(3'b001, 256'h1000 + 256'(i));
    grp_id = 3'b001;
    @(negedge clk);
    check("cr_free_en", {253'd0, en_grp}, 256'h1);
    tick();
    @(negedge clk);
    check("cr_full_fire", {255'd0, addr_ready}, 256'd0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    @(negedge clk);
    check("cr_pop_fire", {255'd0, addr_ready}, 256'd1);
    check("cr_pop_en", {253'd0, en_grp}, 256'h1);
    grp_id = 3'b000;
    data_ready = 1'b1;
    ret_cycle(3'b001, 256'h2000);
    repeat (40) tick();
    check("cr_drain", 256'(sb.size()), 256'd0);

    // Multi-group return
    fire_n(1);
    ret_cycle(3'b101, 256'hF0F);
    @(negedge clk);
    check("mr_err", {253'd0, err_flags}, 256'b010);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    @(negedge clk);
    check("mr_clr", {253'd0, err_flags}, 256'd0);

    // Underflow, then multi-bit request
    ret_cycle(3'b100, 256'h55);
    @(negedge clk);
    check("uf_err", {253'd0, err_flags}, 256'b100);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    grp_id = 3'b011;
    @(negedge clk);
    check("mq_fire", {255'd0, addr_ready}, 256'd0);
    check("mq_en", {253'd0, en_grp}, 256'd0);
    tick();
    grp_id = 3'b000;
    @(negedge clk);
    check("mq_err", {253'd0, err_flags}, 256'b001);
    grp_id = 3'b011; err_clr = 1'b1;
    tick();
    grp_id = 3'b000; err_clr = 1'b0;
    @(negedge clk);
    check("set_wins_clr", {253'd0, err_flags}, 256'b001);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    repeat (4) tick();

    // Burst of 8 returns with ready toggling
    req_base = perf_req;
    fire_n(8);
`ifdef READ_PORT_PERF_CNT_EN
    check("perf_req", {224'd0, perf_req - req_base}, 256'd8);
`else
    check("perf_req", {224'd0, perf_req}, 256'd0);
`endif
    stall_base = perf_stall;
    for (int k = 0; k < 9; k++) begin
      data_ready = k[0];
      if (k < 8) ret_cycle(3'b001, 256'h3000 + 256'(k));
      else tick();
    end
    data_ready = 1'b1;
    repeat (12) tick();
`ifdef READ_PORT_PERF_CNT_EN
    check("perf_stall", {224'd0, perf_stall - stall_base}, 256'd4);
`else
    check("perf_stall", {224'd0, perf_stall}, 256'd0);
`endif
    check("burst_drain", 256'(sb.size()), 256'd0);

    // Reset with buffered data
    data_ready = 1'b0;
    fire_n(5);
    for (int i = 0; i < 5; i++) ret_cycle(3'b001, 256'h4000 + 256'(i));
    rst_n = 1'b0;
    #1;
    check("mrst_vld", {255'd0, data_valid}, 256'd0);
    check("mrst_data", data, 256'd0);
    check("mrst_perf", {224'd0, perf_req}, 256'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_vld_rel", {255'd0, data_valid}, 256'd0);
    tick();
    @(negedge clk);
    check("mrst_fifo_empty", {255'd0, data_valid}, 256'd0);
    ret_cycle(3'b001, 256'h77);
    @(negedge clk);
    check("mrst_uf", {253'd0, err_flags}, 256'b100);
    data_ready = 1'b1;
    repeat (4) tick();
    check("mrst_drain", 256'(sb.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
